// File: rtl/msb_read_port.sv
// msb_read_port: per-channel line-write / word-read memory with credit-based
// request flow control and an in-order fall-through output buffer.
// Each channel stores WAYS word banks indexed by line {st,cl}; a whole line is
// written in one cycle, a single word is read back with RD_LAT cycles latency.
// Optional macro MSB_RD_BYPASS_EN: a read colliding with a same-cycle write of
// the same line returns the newly written word (default build: read-first).
module msb_read_port #(
  parameter int DATA_WIDTH = 64,
  parameter int CHANNELS   = 2,
  parameter int NSTRMS     = 32,
  parameter int NCL        = 16,
  parameter int WAYS       = 8,
  parameter int RD_LAT     = 2,
  parameter int CREDITS    = RD_LAT + 2,
  localparam int L1_NSTRMS = NSTRMS / CHANNELS,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int ST_W      = (L1_NSTRMS > 1) ? $clog2(L1_NSTRMS) : 1,
  localparam int CL_W      = (NCL > 1) ? $clog2(NCL) : 1,
  localparam int OF_W      = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int DEPTH     = L1_NSTRMS * NCL,
  localparam int LA_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                i_v,
  output logic                                i_r,
  input  logic [CH_W-1:0]                     i_ra_ch,
  input  logic [ST_W-1:0]                     i_ra_st,
  input  logic [CL_W-1:0]                     i_ra_cl,
  input  logic [OF_W-1:0]                     i_ra_of,
  output logic                                o_v,
  input  logic                                o_r,
  output logic [DATA_WIDTH-1:0]               o_rd,
  output logic                                o_err,
  input  logic [CHANNELS-1:0]                 i_we,
  input  logic [CHANNELS*LA_W-1:0]            i_wa,
  input  logic [CHANNELS*WAYS*DATA_WIDTH-1:0] i_wd
);

  localparam int CNT_W = $clog2(CREDITS + 1);
  localparam int PTR_W = (CREDITS > 1) ? $clog2(CREDITS) : 1;
  localparam int IDX_W = (CHANNELS * WAYS > 1) ? $clog2(CHANNELS * WAYS) : 1;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic            accept;
  logic            ch_ok;
  logic [LA_W-1:0] rd_line;
  logic            o_pop;

  assign accept  = i_v & i_r;
  assign ch_ok   = int'(i_ra_ch) < CHANNELS;
  // Line index is st*NCL+cl, identical to {st,cl} when NCL is a power of two
  assign rd_line = LA_W'(int'(i_ra_st) * NCL + int'(i_ra_cl));

  // ---------------------------------------------------------------------------
  // Per-channel memories: one bank per word offset so a full line writes at once
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rd_word [CHANNELS*WAYS];

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic            rd_en;
    logic [LA_W-1:0] wr_line;

    assign rd_en   = accept && ch_ok && (int'(i_ra_ch) == gi);
    assign wr_line = i_wa[gi*LA_W +: LA_W];

    for (genvar gj = 0; gj < WAYS; gj++) begin : g_way
      logic [DATA_WIDTH-1:0] mem [DEPTH];
      logic [DATA_WIDTH-1:0] rd_q;

      // Bank write plus registered read; the read samples pre-write contents
      always_ff @(posedge clk) begin
        if (i_we[gi]) mem[wr_line] <= i_wd[(gi*WAYS+gj)*DATA_WIDTH +: DATA_WIDTH];
        if (rd_en) rd_q <= mem[rd_line];
      end

      assign rd_word[gi*WAYS+gj] = rd_q;
    end
  end

`ifdef MSB_RD_BYPASS_EN
  logic                  byp_hit;
  logic [DATA_WIDTH-1:0] byp_word;
  logic                  s1_byp_q;
  logic [DATA_WIDTH-1:0] s1_bypw_q;

  // Detect a same-cycle write to the line being read and pick the new word
  always_comb begin
    byp_hit  = 1'b0;
    byp_word = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_ok && (int'(i_ra_ch) == c) && i_we[c] &&
          (i_wa[c*LA_W +: LA_W] == rd_line)) begin
        byp_hit  = 1'b1;
        byp_word = i_wd[(c*WAYS + int'(i_ra_of))*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Carry the collision word alongside the memory read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_byp_q  <= 1'b0;
      s1_bypw_q <= '0;
    end else if (accept) begin
      s1_byp_q  <= byp_hit;
      s1_bypw_q <= byp_word;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Stage 1: tag registered alongside the memory read
  // ---------------------------------------------------------------------------
  logic                  s1_v_q;
  logic                  s1_err_q;
  logic [CH_W-1:0]       s1_ch_q;
  logic [OF_W-1:0]       s1_of_q;
  logic [IDX_W-1:0]      s1_idx;
  logic [DATA_WIDTH-1:0] s1_word;

  // Stage-1 valid and request tag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_v_q   <= 1'b0;
      s1_err_q <= 1'b0;
      s1_ch_q  <= '0;
      s1_of_q  <= '0;
    end else begin
      s1_v_q <= accept;
      if (accept) begin
        s1_err_q <= !ch_ok;
        s1_ch_q  <= i_ra_ch;
        s1_of_q  <= i_ra_of;
      end
    end
  end

  // Select the addressed word; out-of-range channels return zero
  always_comb begin
    s1_idx  = '0;
    s1_word = '0;
    if (!s1_err_q) begin
      s1_idx  = IDX_W'(int'(s1_ch_q) * WAYS + int'(s1_of_q));
      s1_word = rd_word[s1_idx];
`ifdef MSB_RD_BYPASS_EN
      if (s1_byp_q) s1_word = s1_bypw_q;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Delay stages 2..RD_LAT
  // ---------------------------------------------------------------------------
  logic                  st_v [RD_LAT];
  logic                  st_e [RD_LAT];
  logic [DATA_WIDTH-1:0] st_d [RD_LAT];

  assign st_v[0] = s1_v_q;
  assign st_e[0] = s1_err_q;
  assign st_d[0] = s1_word;

  for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_stage
    logic                  v_q;
    logic                  e_q;
    logic [DATA_WIDTH-1:0] d_q;

    // Stage valid/error flags are cleared by reset so in-flight reads vanish
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        v_q <= 1'b0;
        e_q <= 1'b0;
      end else begin
        v_q <= st_v[gi-1];
        e_q <= st_e[gi-1];
      end
    end

    // Data path needs no reset; it is qualified by the valid flag
    always_ff @(posedge clk) begin
      d_q <= st_d[gi-1];
    end

    assign st_v[gi] = v_q;
    assign st_e[gi] = e_q;
    assign st_d[gi] = d_q;
  end

  logic                  lv;
  logic                  le;
  logic [DATA_WIDTH-1:0] ld;

  assign lv = st_v[RD_LAT-1];
  assign le = st_e[RD_LAT-1];
  assign ld = st_d[RD_LAT-1];

  // ---------------------------------------------------------------------------
  // Fall-through output buffer: pipeline output goes straight out when empty
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] fifo_d [CREDITS];
  logic                  fifo_e [CREDITS];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      fcnt_q;
  logic [CNT_W-1:0]      credit_q;
  logic                  buf_empty;
  logic                  push;
  logic                  pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (int'(p) == CREDITS - 1) return '0;
    return p + PTR_W'(1);
  endfunction

  assign buf_empty = (fcnt_q == '0);
  assign push      = lv && !(buf_empty && o_r);
  assign pop       = !buf_empty && o_r;
  assign o_v       = !buf_empty || lv;
  assign o_pop     = o_v && o_r;
  assign o_rd      = !buf_empty ? fifo_d[rd_ptr_q] : (lv ? ld : '0);
  assign o_err     = !buf_empty ? fifo_e[rd_ptr_q] : (lv & le);
  assign i_r       = (credit_q != '0);

  // Buffer pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      fcnt_q <= fcnt_q + CNT_W'(1);
      else if (!push && pop) fcnt_q <= fcnt_q - CNT_W'(1);
    end
  end

  // Buffer storage, qualified by the occupancy count
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_d[wr_ptr_q] <= ld;
      fifo_e[wr_ptr_q] <= le;
    end
  end

  // Credits: one per request in flight or buffered, returned on output pop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              credit_q <= CNT_W'(CREDITS);
    else if (accept && !o_pop) credit_q <= credit_q - CNT_W'(1);
    else if (!accept && o_pop) credit_q <= credit_q + CNT_W'(1);
  end

endmodule

// File: tb/tb_msb_read_port.sv
// Testbench for msb_read_port (CHANNELS=3 so an out-of-range channel exists).
// Stimulus pushes expected responses into a queue; a monitor pops and compares.
`timescale 1ns/1ps
module tb_msb_read_port;
  localparam int DW      = 64;
  localparam int CH      = 3;
  localparam int NS      = 32;
  localparam int NCL     = 16;
  localparam int WAYS    = 8;
  localparam int RD_LAT  = 2;
  localparam int CREDITS = 4;
  localparam int L1      = NS / CH;
  localparam int CH_W    = (CH > 1) ? $clog2(CH) : 1;
  localparam int ST_W    = (L1 > 1) ? $clog2(L1) : 1;
  localparam int CL_W    = (NCL > 1) ? $clog2(NCL) : 1;
  localparam int OF_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LA_W    = (L1 * NCL > 1) ? $clog2(L1 * NCL) : 1;

  localparam logic [DW-1:0] PAT_A = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [DW-1:0] PAT_B = 64'hBBBB_BBBB_BBBB_BBBB;
`ifdef MSB_RD_BYPASS_EN
  localparam logic [DW-1:0] COLL_EXP = PAT_B;
`else
  localparam logic [DW-1:0] COLL_EXP = PAT_A;
`endif

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    i_v;
  logic                    i_r;
  logic [CH_W-1:0]         i_ra_ch;
  logic [ST_W-1:0]         i_ra_st;
  logic [CL_W-1:0]         i_ra_cl;
  logic [OF_W-1:0]         i_ra_of;
  logic                    o_v;
  logic                    o_r;
  logic [DW-1:0]           o_rd;
  logic                    o_err;
  logic [CH-1:0]           i_we;
  logic [CH*LA_W-1:0]      i_wa;
  logic [CH*WAYS*DW-1:0]   i_wd;

  msb_read_port #(
    .DATA_WIDTH(DW), .CHANNELS(CH), .NSTRMS(NS), .NCL(NCL),
    .WAYS(WAYS), .RD_LAT(RD_LAT), .CREDITS(CREDITS)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .i_v(i_v), .i_r(i_r),
    .i_ra_ch(i_ra_ch), .i_ra_st(i_ra_st), .i_ra_cl(i_ra_cl), .i_ra_of(i_ra_of),
    .o_v(o_v), .o_r(o_r), .o_rd(o_rd), .o_err(o_err),
    .i_we(i_we), .i_wa(i_wa), .i_wd(i_wd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          e;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   resp_n = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int ch, input int st, input int cl,
                        input logic [DW-1:0] base, input bit inc);
    i_we[ch] = 1'b1;
    i_wa[ch*LA_W +: LA_W] = LA_W'(st * NCL + cl);
    for (int k = 0; k < WAYS; k++)
      i_wd[(ch*WAYS+k)*DW +: DW] = inc ? base + DW'(k) : base;
  endtask

  task automatic clr_wr();
    i_we = '0;
  endtask

  // Drive a request; queue its expected response if it will be accepted
  task automatic issue(input int ch, input int st, input int cl, input int of,
                       input logic [DW-1:0] d, input logic e);
    exp_t x;
    i_v     = 1'b1;
    i_ra_ch = CH_W'(ch);
    i_ra_st = ST_W'(st);
    i_ra_cl = CL_W'(cl);
    i_ra_of = OF_W'(of);
    x.d = d;
    x.e = e;
    if (i_r) exp_q.push_back(x);
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: pops and compares every accepted response; checks hold while stalled
  initial begin
    logic          prev_stall;
    logic [DW-1:0] prev_d;
    logic          prev_e;
    exp_t          x;
    prev_stall = 1'b0;
    prev_d     = '0;
    prev_e     = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_v", 64'(o_v), 64'd1);
          chk("hold_rd", o_rd, prev_d);
          chk("hold_err", 64'(o_err), 64'(prev_e));
        end
        if (o_v && o_r) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got data 0x%0h err %0b, required no response", o_rd, o_err);
          end else begin
            x = exp_q.pop_front();
            $display("resp %0d: data=0x%0h err=%0b (expected 0x%0h err=%0b)", resp_n, o_rd, o_err, x.d, x.e);
            resp_n++;
            chk("resp_data", o_rd, x.d);
            chk("resp_err", 64'(o_err), 64'(x.e));
          end
        end
        prev_stall = o_v && !o_r;
        prev_d     = o_rd;
        prev_e     = o_err;
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    reset_n = 1'b0;
    i_v = 1'b0; i_ra_ch = '0; i_ra_st = '0; i_ra_cl = '0; i_ra_of = '0;
    o_r = 1'b1; i_we = '0; i_wa = '0; i_wd = '0;

    // Reset state
    #12;
    chk("rst_i_r", 64'(i_r), 64'd1);
    chk("rst_o_v", 64'(o_v), 64'd0);
    chk("rst_o_rd", o_rd, 64'd0);
    chk("rst_o_err", 64'(o_err), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick();

    // Concurrent line writes on all channels, then read two cycles later
    set_wr(1, 3, 5, 64'h10, 1'b1);
    set_wr(0, 3, 5, 64'h20, 1'b1);
    set_wr(2, 9, 15, 64'h30, 1'b1);
    tick();
    clr_wr();
    tick();
    issue(1, 3, 5, 1, 64'h11, 1'b0);
    tick();
    i_v = 1'b0;
    chk("lat_t1_ov", 64'(o_v), 64'd0);
    tick();
    chk("lat_t2_ov", 64'(o_v), 64'd1);
    issue(0, 3, 5, 7, 64'h27, 1'b0); tick();
    issue(2, 9, 15, 0, 64'h30, 1'b0); tick();
    issue(1, 3, 5, 7, 64'h17, 1'b0); tick();
    i_v = 1'b0;
    wait_drain(20);

    // Credit exhaustion with the output stalled
    o_r = 1'b0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      chk("credit_ir", 64'(i_r), (i < CREDITS) ? 64'd1 : 64'd0);
      if (i_r) acc++;
      issue(0, 3, 5, i, 64'h20 + 64'(i), 1'b0);
      tick();
    end
    i_v = 1'b0;
    chk("credit_accepted", 64'(acc), 64'(CREDITS));
    tick();
    chk("stall_ov", 64'(o_v), 64'd1);
    tick();
    o_r = 1'b1;
    wait_drain(20);
    tick();
    chk("credit_back_ir", 64'(i_r), 64'd1);

    // Out-of-range channel: zero data, error flag, same latency
    issue(3, 1, 2, 3, 64'h0, 1'b1);
    tick();
    i_v = 1'b0;
    chk("err_lat_t1_ov", 64'(o_v), 64'd0);
    tick();
    chk("err_lat_t2_ov", 64'(o_v), 64'd1);
    chk("err_lat_t2_err", 64'(o_err), 64'd1);
    wait_drain(20);
    o_r = 1'b0;
    for (int i = 0; i < CREDITS; i++) begin
      issue(3, i, i, i, 64'h0, 1'b1);
      tick();
    end
    i_v = 1'b0;
    chk("err_credit_empty_ir", 64'(i_r), 64'd0);
    o_r = 1'b1;
    wait_drain(20);
    tick();
    chk("err_credit_back_ir", 64'(i_r), 64'd1);

    // Same-cycle write/read collision
    set_wr(2, 1, 2, PAT_A, 1'b0);
    tick();
    clr_wr();
    set_wr(2, 1, 2, PAT_B, 1'b0);
    issue(2, 1, 2, 4, COLL_EXP, 1'b0);
    tick();
    clr_wr();
    issue(2, 1, 2, 4, PAT_B, 1'b0);
    tick();
    i_v = 1'b0;
    wait_drain(20);
    tick();

    // Sixteen back-to-back reads with output always ready
    for (int i = 0; i < 19; i++) begin
      if (i < 16) begin
        chk("b2b_ir", 64'(i_r), 64'd1);
        if (i % 2 == 1) issue(1, 3, 5, i % 8, 64'h10 + 64'(i % 8), 1'b0);
        else            issue(0, 3, 5, i % 8, 64'h20 + 64'(i % 8), 1'b0);
      end else begin
        i_v = 1'b0;
      end
      chk("b2b_ov", 64'(o_v), (i >= RD_LAT && i < 16 + RD_LAT) ? 64'd1 : 64'd0);
      tick();
    end
    wait_drain(20);

    // Reset with three requests outstanding
    o_r = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue(1, 3, 5, i, 64'h10 + 64'(i), 1'b0);
      tick();
    end
    i_v = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst_ov", 64'(o_v), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ov", 64'(o_v), 64'd0);
    chk("mid_rst_ir", 64'(i_r), 64'd1);
    chk("mid_rst_rd", o_rd, 64'd0);
    chk("mid_rst_err", 64'(o_err), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    o_r = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("post_rst_ov", 64'(o_v), 64'd0);
      tick();
    end
    // Memory contents survive reset
    issue(1, 3, 5, 1, 64'h11, 1'b0);
    tick();
    i_v = 1'b0;
    wait_drain(20);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/msb_read_port.md
MSB_READ_PORT -- requirements
Module: msb_read_port

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, width of one returned word.
REQ-002 SHALL have parameter CHANNELS, default 2, number of write channels; any value 1..8, power of two not required.
REQ-003 SHALL have parameter NSTRMS, default 32, total streams; streams per channel L1_NSTRMS = NSTRMS/CHANNELS.
REQ-004 SHALL have parameter NCL, default 16, cache lines per stream.
REQ-005 SHALL have parameter WAYS, default 8, words per cache line.
REQ-006 SHALL have parameter RD_LAT, default 2, memory read latency in cycles, legal 1..4.
REQ-007 SHALL have parameter CREDITS, default RD_LAT+2, output buffer depth and credit count.
REQ-008 SHALL have ports: clk  in  1  sole clock; reset_n  in  1  asynchronous, active-low reset.
REQ-009 SHALL have ports: i_v  in  1  read request valid; i_r  out  1  read request ready.
REQ-010 SHALL have ports: i_ra_ch  in  max(1,clog2(CHANNELS)); i_ra_st  in  clog2(L1_NSTRMS); i_ra_cl  in  clog2(NCL); i_ra_of  in  clog2(WAYS).
REQ-011 SHALL have ports: o_v  out  1; o_r  in  1; o_rd  out  DATA_WIDTH  read word; o_err  out  1  channel out of range.
REQ-012 SHALL have ports: i_we  in  CHANNELS; i_wa  in  CHANNELS*clog2(L1_NSTRMS*NCL)  line address {st,cl}; i_wd  in  CHANNELS*WAYS*DATA_WIDTH  full line.

Function
REQ-013 SHALL hold per channel one memory of L1_NSTRMS*NCL*WAYS words, word address {st,cl,of}; word k of i_wd slice is offset k.
REQ-014 SHALL write all WAYS words of a line in the cycle i_we[c] is high; channels written independently and concurrently.
REQ-015 SHALL maintain credit counter, reset value CREDITS; i_r = (counter != 0).
REQ-016 SHALL decrement counter on request accept (i_v & i_r), increment on output pop (o_v & o_r), hold when both or neither occur.
REQ-017 SHALL present data of a request accepted in cycle t at o_v in cycle t+RD_LAT when output buffer empty (fall-through buffer).
REQ-018 SHALL return results strictly in request order; buffer never overflows because outstanding requests never exceed CREDITS.
REQ-019 SHALL, for i_ra_ch >= CHANNELS, not access memory, return o_rd = 0 with o_err = 1, same latency and credit accounting.
REQ-020 SHALL hold o_v, o_rd, o_err stable while o_v & !o_r.
REQ-021 SHALL, for a write to line L and read of a word of L accepted the same cycle, return the pre-write data (read-first); read accepted a cycle later returns new data.
REQ-022 SHALL sustain one request and one response per cycle when o_r held high.

Reset
REQ-023 SHALL, on reset_n low, asynchronously clear o_v, o_err, o_rd to 0, in-flight pipeline valids, buffer pointers, and set counter to CREDITS (i_r = 1).
REQ-024 SHALL discard requests in flight when reset asserts mid-operation; memory contents are not cleared.
REQ-025 SHALL deassert reset synchronously to clk.

Configuration
REQ-026 SHALL provide macro MSB_RD_BYPASS_EN; when defined, same-cycle write/read collision (REQ-021) returns the newly written data; when undefined, read-first behaviour; latency unchanged either way.

Verification
REQ-027 Write line ch1 st3 cl5 with words 0x10..0x17, read of1 two cycles later, o_r=1 -> o_v at t+2, o_rd=0x11, o_err=0.
REQ-028 o_r=0, issue 8 requests, CREDITS=4 -> exactly 4 accepted, i_r=0 from 5th cycle; release o_r -> 4 words in order, i_r reasserts.
REQ-029 CHANNELS=3, request ch3 -> o_rd=0, o_err=1 after RD_LAT, credit returned on pop.
REQ-030 Line holds 0xAA.., same-cycle write 0xBB.. and read -> 0xAA without MSB_RD_BYPASS_EN, 0xBB with it.
REQ-031 Back-to-back 16 reads, o_r=1 -> 16 consecutive o_v cycles, counter never below CREDITS-RD_LAT.
REQ-032 Reset_n low with 3 outstanding -> o_v=0 immediately, i_r=1, no stale output after release.
